processor_datapath: RTL and testbench

//   Datapath slave to unidade_controle: R0..R7, A, G, IR, shared 16-bit bus mux and ULA.

---
 rtl/proc_pkg.sv | 19 +
 rtl/processor_datapath_regn.sv | 29 ++
 rtl/processor_datapath.sv | 97 +++++++++
 tb/tb_processor_datapath.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: constants shared by the datapath and the control unit.
//   ULA operation codes, instruction opcodes and default widths.
package proc_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int IR_W_DEF   = 9;
   localparam int NREGS_DEF  = 8;

   // ULA operation select (Ulaop)
   localparam logic [1:0] ULA_ADD  = 2'b00;
   localparam logic [1:0] ULA_SUB  = 2'b01;  // A - bus
   localparam logic [1:0] ULA_AND  = 2'b10;
   localparam logic [1:0] ULA_PASS = 2'b11;  // result = bus

   // Instruction opcodes (IR[IR_W-1 -: 3])
   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;
endpackage

// File: rtl/processor_datapath_regn.sv
// regn: N-bit register with asynchronous active-high clear and load enable.
//   Clock  in  1  rising-edge clock
//   Resetn in  1  asynchronous active-high clear
//   en     in  1  load enable
//   d      in  N  load data
//   q      out N  register contents
module regn #(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);
   logic [N-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (en) q_d = d;
   end

   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/processor_datapath.sv
// processor_datapath: register file R0..R(NREGS-1), A, G, IR, shared bus and ULA,
// driven by control strobes from unidade_controle.
//   Clock      in   1       rising-edge clock
//   Resetn     in   1       asynchronous ACTIVE-HIGH reset
//   DIN        in   DATA_W  memory data / immediate
//   IRin       in   1       load IR from DIN upper bits
//   Rin/Rout   in   NREGS   one-hot register load / bus drive
//   Ain, Gin   in   1       load A from bus / G from ULA
//   Gout       in   1       G drives bus
//   Ulaop      in   2       ULA operation
//   DINout     in   1       DIN drives bus
//   Instrucao  out  IR_W    IR contents
//   GRout      out  DATA_W  G contents
//   Gzero      out  1       G == 0
//   BusWires   out  DATA_W  current bus value
//   BusErr     out  1       sticky multiple-driver flag
module processor_datapath
   import proc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IR_W   = IR_W_DEF,
   parameter int NREGS  = NREGS_DEF
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [DATA_W-1:0] DIN,
   input  logic              IRin,
   input  logic [NREGS-1:0]  Rin,
   input  logic [NREGS-1:0]  Rout,
   input  logic              Ain,
   input  logic              Gin,
   input  logic              Gout,
   input  logic [1:0]        Ulaop,
   input  logic              DINout,
   output logic [IR_W-1:0]   Instrucao,
   output logic [DATA_W-1:0] GRout,
   output logic              Gzero,
   output logic [DATA_W-1:0] BusWires,
   output logic              BusErr
);
   localparam int CNT_W = $clog2(NREGS + 3);

   logic [NREGS-1:0][DATA_W-1:0] r_q;
   logic [DATA_W-1:0]            a_q, g_q, bus, ula_res;
   logic [CNT_W-1:0]             drv_cnt;
   logic                         bus_err_q, bus_err_d;

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_r
      regn #(.N(DATA_W)) u_r (
         .Clock(Clock), .Resetn(Resetn), .en(Rin[gi]), .d(bus), .q(r_q[gi]));
   end

   regn #(.N(DATA_W)) u_a (
      .Clock(Clock), .Resetn(Resetn), .en(Ain), .d(bus), .q(a_q));
   regn #(.N(DATA_W)) u_g (
      .Clock(Clock), .Resetn(Resetn), .en(Gin), .d(ula_res), .q(g_q));
   regn #(.N(IR_W)) u_ir (
      .Clock(Clock), .Resetn(Resetn), .en(IRin), .d(DIN[DATA_W-1 -: IR_W]), .q(Instrucao));

   // Bus priority DINout > Gout > lowest-index Rout. Scanning registers from the
   // top down lets the lowest set index win.
   always_comb begin
      bus = '0;
      for (int i = NREGS - 1; i >= 0; i--)
         if (Rout[i]) bus = r_q[i];
      if (Gout)   bus = g_q;
      if (DINout) bus = DIN;
   end

   // ULA sees A before the edge, so Ain and Gin together use the old A.
   always_comb begin
      ula_res = bus;
      case (Ulaop)
         ULA_ADD:  ula_res = a_q + bus;
         ULA_SUB:  ula_res = a_q - bus;
         ULA_AND:  ula_res = a_q & bus;
         default:  ula_res = bus;
      endcase
   end

   always_comb begin
      drv_cnt = CNT_W'(DINout) + CNT_W'(Gout);
      for (int i = 0; i < NREGS; i++)
         drv_cnt = drv_cnt + CNT_W'(Rout[i]);
      bus_err_d = bus_err_q | (drv_cnt > CNT_W'(1));
   end

   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn) bus_err_q <= 1'b0;
      else        bus_err_q <= bus_err_d;
   end

   assign GRout    = g_q;
   assign Gzero    = (g_q == '0);
   assign BusWires = bus;
   assign BusErr   = bus_err_q;
endmodule

// File: tb/tb_processor_datapath.sv
// Self-checking bench for processor_datapath: directed scenarios followed by
// randomized strobes compared against a behavioural model of the datapath.
module tb_processor_datapath;
   logic        Clock = 1'b0;
   logic        Resetn;
   logic [15:0] DIN;
   logic        IRin, Ain, Gin, Gout, DINout;
   logic [7:0]  Rin, Rout;
   logic [1:0]  Ulaop;
   logic [8:0]  Instrucao;
   logic [15:0] GRout, BusWires;
   logic        Gzero, BusErr;

   processor_datapath dut (
      .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .IRin(IRin), .Rin(Rin), .Rout(Rout),
      .Ain(Ain), .Gin(Gin), .Gout(Gout), .Ulaop(Ulaop), .DINout(DINout),
      .Instrucao(Instrucao), .GRout(GRout), .Gzero(Gzero), .BusWires(BusWires),
      .BusErr(BusErr));

   always #5 Clock = ~Clock;

   // behavioural model state
   logic [15:0] m_r [8];
   logic [15:0] m_a, m_g;
   logic [8:0]  m_ir;
   logic        m_err;
   int          n_pass = 0, n_tot = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [15:0] m_bus();
      if (DINout) return DIN;
      if (Gout)   return m_g;
      for (int i = 0; i < 8; i++)
         if (Rout[i]) return m_r[i];
      return 16'h0000;
   endfunction

   task automatic idle();
      DIN = 16'h0; IRin = 0; Rin = 0; Rout = 0; Ain = 0; Gin = 0; Gout = 0;
      Ulaop = 2'b00; DINout = 0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
      m_a = 0; m_g = 0; m_ir = 0; m_err = 0;
   endtask

   // Called just after a falling edge with inputs set; checks bus, clocks once,
   // checks registered outputs, returns after the next falling edge.
   task automatic step();
      logic [15:0] b, res;
      int drv;
      #1;
      b = m_bus();
      chk("bus", BusWires, b);
      case (Ulaop)
         2'b00:   res = m_a + b;
         2'b01:   res = m_a - b;
         2'b10:   res = m_a & b;
         default: res = b;
      endcase
      drv = int'(DINout) + int'(Gout) + $countones(Rout);
      @(posedge Clock);
      for (int i = 0; i < 8; i++) if (Rin[i]) m_r[i] = b;
      if (Ain) m_a = b;
      if (Gin) m_g = res;
      if (IRin) m_ir = DIN[15:7];
      if (drv > 1) m_err = 1'b1;
      #1;
      chk("ir", Instrucao, m_ir);
      chk("g", GRout, m_g);
      chk("gzero", Gzero, m_g == 16'h0);
      chk("buserr", BusErr, m_err);
      @(negedge Clock);
   endtask

   task automatic load_reg(input int idx, input logic [15:0] v);
      idle(); DIN = v; DINout = 1; Rin[idx] = 1'b1; step();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_ir"}, Instrucao, 9'h0);
      chk({tag, "_g"}, GRout, 16'h0);
      chk({tag, "_gzero"}, Gzero, 1'b1);
      chk({tag, "_buserr"}, BusErr, 1'b0);
   endtask

   initial begin
      idle();
      Resetn = 1'b1;
      Rin = 'x; Rout = 'x; Ain = 'x; Gin = 'x; DINout = 'x;  // ignored during reset
      model_clear();
      repeat (3) @(negedge Clock);
      #1 reset_checks("rst");
      idle();
      #1 chk("rst_bus", BusWires, 16'h0);
      Resetn = 1'b0;
      @(negedge Clock);

      // R2 <- DIN, then R7 <- R2
      load_reg(2, 16'h1234);
      idle(); Rout = 8'h04; Rin = 8'h80; step();
      idle(); Rout = 8'h80; #1 chk("t2_r7", BusWires, 16'h1234); step();

      // G = R1 - R2 = 5 - 7
      load_reg(1, 16'd5);
      load_reg(2, 16'd7);
      idle(); Rout = 8'h02; Ain = 1; step();
      idle(); Rout = 8'h04; Gin = 1; Ulaop = 2'b01; step();
      chk("t3_g", GRout, 16'hFFFE);
      chk("t3_gzero", Gzero, 1'b0);
      idle(); Gout = 1; Rin = 8'h02; step();
      idle(); Rout = 8'h02; #1 chk("t3_r1", BusWires, 16'hFFFE); step();

      // wraparound add and AND
      idle(); DIN = 16'hFFFF; DINout = 1; Ain = 1; step();
      idle(); DIN = 16'h0001; DINout = 1; Gin = 1; Ulaop = 2'b00; step();
      chk("t4_wrap", GRout, 16'h0000);
      chk("t4_gzero", Gzero, 1'b1);
      idle(); DIN = 16'h0F0F; DINout = 1; Ain = 1; step();
      idle(); DIN = 16'h00FF; DINout = 1; Gin = 1; Ulaop = 2'b10; step();
      chk("t4_and", GRout, 16'h000F);
      // Ain & Gin together: G uses old A (0F0F + 0001)
      idle(); DIN = 16'h0001; DINout = 1; Ain = 1; Gin = 1; Ulaop = 2'b00; step();
      chk("t4_olda", GRout, 16'h0F10);

      // IR load and Rin=Rout self-reload
      idle(); DIN = 16'b1010110000000000; IRin = 1; step();
      chk("t6_ir", Instrucao, 9'b101011000);
      load_reg(3, 16'h3333);
      idle(); Rin = 8'h08; Rout = 8'h08; step();
      idle(); Rout = 8'h08; #1 chk("t6_r3", BusWires, 16'h3333); step();

      // bus contention: DIN wins, BusErr sticks
      load_reg(0, 16'h5555);
      idle(); DIN = 16'hAAAA; DINout = 1; Rout = 8'h01; #1 chk("t5_bus", BusWires, 16'hAAAA);
      step();
      chk("t5_err", BusErr, 1'b1);
      idle(); repeat (3) step();
      chk("t5_sticky", BusErr, 1'b1);

      // mid-sequence reset with strobes active clears immediately
      idle(); DIN = 16'h7777; DINout = 1; Rin = 8'hFF; Gin = 1; IRin = 1; Ulaop = 2'b11;
      #2 Resetn = 1'b1;
      #1 model_clear(); reset_checks("midrst");
      @(negedge Clock);
      Resetn = 1'b0;
      idle(); Rout = 8'h01; step();  // R0 cleared

      // randomized strobes
      for (int c = 0; c < 400; c++) begin
         if (c % 80 == 79) begin
            Resetn = 1'b1; #1 model_clear(); reset_checks("rnd_rst");
            @(negedge Clock); Resetn = 1'b0;
         end
         idle();
         DIN   = 16'($urandom);
         Ulaop = 2'($urandom);
         IRin  = ($urandom_range(0, 3) == 0);
         Ain   = ($urandom_range(0, 2) == 0);
         Gin   = ($urandom_range(0, 1) == 0);
         Rin   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
         case ($urandom_range(0, 9))
            0:       DINout = 1;
            1, 2:    Gout = 1;
            9:       begin Rout = 8'($urandom); DINout = $urandom_range(0, 1) == 1; end
            default: Rout = 8'h1 << $urandom_range(0, 7);
         endcase
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
